// File: rtl/me_pkg.sv
// Shared constants and types for the motion-estimation best-match tracker.
package me_pkg;
    localparam int MACRO_DIM  = 16;
    localparam int SEARCH_DIM = 48;
    localparam int POS        = SEARCH_DIM - MACRO_DIM;
    localparam int NCAND      = POS * POS;
    localparam int SAD_W      = 16;
    localparam int POS_W      = $clog2(POS);

    typedef logic signed [5:0] mv_t;

    typedef enum logic [1:0] {IDLE, SCAN, DONE} state_t;

    // Scan coordinate (0..POS-1) to displacement centred on the macroblock.
    function automatic mv_t to_mv(input logic [POS_W-1:0] p);
        return mv_t'({1'b0, p}) - mv_t'(POS / 2);
    endfunction
endpackage

// File: rtl/me_scan_pos.sv
// Column-serpentine scan position counters; emits the signed motion vector
// of the candidate currently expected on the SAD stream.
module me_scan_pos
    import me_pkg::*;
(
    input  logic clk,
    input  logic rst_n,
    input  logic clr,
    input  logic adv,
    output mv_t  mv_x,
    output mv_t  mv_y,
    output logic last
);
    logic [POS_W-1:0] r_col;
    logic [POS_W-1:0] r_row_idx;
    logic [POS_W-1:0] w_row;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_col     <= '0;
            r_row_idx <= '0;
        end else if (clr) begin
            r_col     <= '0;
            r_row_idx <= '0;
        end else if (adv) begin
            r_row_idx <= r_row_idx + 1'b1;
            if (&r_row_idx)
                r_col <= r_col + 1'b1;
        end
    end

    // Odd columns walk upward: 31 - row_idx is the bitwise complement.
    assign w_row = r_col[0] ? ~r_row_idx : r_row_idx;
    assign mv_x  = to_mv(r_col);
    assign mv_y  = to_mv(w_row);
    assign last  = (&r_col) & (&r_row_idx);
endmodule

// File: rtl/me_best_match.sv
// Tracks the minimum SAD over one search window and its motion vector;
// pulses done after the last candidate and holds the result.
module me_best_match
    import me_pkg::*;
(
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             valid,
    input  logic [SAD_W-1:0] sad,
    output logic             busy,
    output logic             done,
    output logic [SAD_W-1:0] min_sad,
    output mv_t              mv_x,
    output mv_t              mv_y
);
    localparam mv_t MV_ORIGIN = -mv_t'(POS / 2);

    state_t           r_state;
    state_t           w_next;
    logic [SAD_W-1:0] r_min_sad;
    mv_t              r_mv_x;
    mv_t              r_mv_y;
    mv_t              w_pos_x;
    mv_t              w_pos_y;
    logic             w_last;
    logic             w_adv;
    logic             w_first;
    logic             w_take;

    // A start in the same cycle as a valid discards that valid.
    assign w_adv = (r_state == SCAN) && valid && !start;

    me_scan_pos u_pos (
        .clk  (clk),
        .rst_n(rst_n),
        .clr  (start),
        .adv  (w_adv),
        .mv_x (w_pos_x),
        .mv_y (w_pos_y),
        .last (w_last)
    );

    // Position (-16,-16) only occurs as candidate 0 within a scan.
    assign w_first = (w_pos_x == MV_ORIGIN) && (w_pos_y == MV_ORIGIN);
    assign w_take  = w_adv && (w_first || (sad < r_min_sad));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            r_state <= IDLE;
        else
            r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        unique case (r_state)
            IDLE:    if (start) w_next = SCAN;
            SCAN:    if (start) w_next = SCAN;
                     else if (valid && w_last) w_next = DONE;
            DONE:    w_next = start ? SCAN : IDLE;
            default: w_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_min_sad <= '1;
            r_mv_x    <= '0;
            r_mv_y    <= '0;
        end else if (start) begin
            r_min_sad <= '1;
            r_mv_x    <= '0;
            r_mv_y    <= '0;
        end else if (w_take) begin
            r_min_sad <= sad;
            r_mv_x    <= w_pos_x;
            r_mv_y    <= w_pos_y;
        end
    end

    assign busy    = (r_state == SCAN);
    assign done    = (r_state == DONE);
    assign min_sad = r_min_sad;
    assign mv_x    = r_mv_x;
    assign mv_y    = r_mv_y;
endmodule

// File: tb/tb_me_best_match.sv
// Directed bench for me_best_match: candidate-index model checked every cycle
// plus hand-computed expectations for each scenario.
module tb_me_best_match;
    import me_pkg::*;

    logic        clk   = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic        valid = 1'b0;
    logic [15:0] sad   = '0;
    logic        busy, done;
    logic [15:0] min_sad;
    mv_t         mv_x, mv_y;

    int checks = 0, failures = 0, done_cnt = 0;

    // Model state: scan flag, number of candidates seen, best so far.
    bit m_scan = 1'b0, m_done = 1'b0;
    int m_cnt = 0, m_min = 65535, m_mx = 0, m_my = 0;

    me_best_match dut (
        .clk(clk), .rst_n(rst_n), .start(start), .valid(valid), .sad(sad),
        .busy(busy), .done(done), .min_sad(min_sad), .mv_x(mv_x), .mv_y(mv_y)
    );

    always #5 clk = ~clk;

    function automatic int cand_x(input int idx);
        return idx / 32 - 16;
    endfunction

    function automatic int cand_y(input int idx);
        int c, ri;
        c  = idx / 32;
        ri = idx % 32;
        return ((c % 2) ? 31 - ri : ri) - 16;
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_scan <= 1'b0; m_done <= 1'b0; m_cnt <= 0;
            m_min <= 65535; m_mx <= 0; m_my <= 0;
        end else begin
            m_done <= 1'b0;
            if (start) begin
                m_scan <= 1'b1; m_cnt <= 0;
                m_min <= 65535; m_mx <= 0; m_my <= 0;
            end else if (m_scan && valid) begin
                if (m_cnt == 0 || int'(sad) < m_min) begin
                    m_min <= int'(sad);
                    m_mx  <= cand_x(m_cnt);
                    m_my  <= cand_y(m_cnt);
                end
                m_cnt <= m_cnt + 1;
                if (m_cnt == NCAND - 1) begin
                    m_scan <= 1'b0;
                    m_done <= 1'b1;
                end
            end
        end
    end

    task automatic cmp();
        checks++;
        if (busy !== m_scan || done !== m_done || int'(min_sad) != m_min ||
            int'(mv_x) != m_mx || int'(mv_y) != m_my) begin
            failures++;
            $display("FAIL model_cmp t=%0t got busy=%0b done=%0b min=%0d mv=(%0d,%0d) want busy=%0b done=%0b min=%0d mv=(%0d,%0d)",
                     $time, busy, done, min_sad, mv_x, mv_y, m_scan, m_done, m_min, m_mx, m_my);
        end
        if (done === 1'b1) done_cnt++;
    endtask

    task automatic lit(input string name, input int got, input int want);
        checks++;
        if (got != want) begin
            failures++;
            $display("FAIL %s got=%0d want=%0d", name, got, want);
        end
    endtask

    // Compare at the falling edge, then return just after the next rising edge.
    task automatic cyc();
        @(negedge clk);
        cmp();
        @(posedge clk);
        #1;
    endtask

    task automatic do_start();
        start = 1'b1;
        cyc();
        start = 1'b0;
    endtask

    task automatic send(input int v, input bit gap);
        valid = 1'b1;
        sad   = v[15:0];
        cyc();
        valid = 1'b0;
        if (gap) cyc();
    endtask

    function automatic int sad_for(input int mode, input int i);
        case (mode)
            0:       return (i < 1000) ? 1000 - i : 0;
            1:       return (i == 32) ? 3 : 500;
            2:       return 65535;
            3:       return (i == 5 || i == 700) ? 100 : 900;
            4:       return 77;
            5:       return int'($urandom_range(0, 65535));
            default: return (i < 10) ? 10 - i : 200;
        endcase
    endfunction

    // Full scan; the final valid is followed immediately by a done check.
    task automatic run_scan(input int mode, input bit b2b, input string tag);
        for (int i = 0; i < NCAND; i++)
            send(sad_for(mode, i), !b2b && i != NCAND - 1);
        lit({tag, "_done_next"}, int'(done), 1);
        cyc();
        cyc();
    endtask

    task automatic lit_res(input string tag, input int s, input int x, input int y);
        lit({tag, "_min"}, int'(min_sad), s);
        lit({tag, "_mvx"}, int'(mv_x), x);
        lit({tag, "_mvy"}, int'(mv_y), y);
    endtask

    initial begin
        int d0;
        cyc();
        cyc();
        lit("rst_busy", int'(busy), 0);
        lit("rst_done", int'(done), 0);
        lit_res("rst", 65535, 0, 0);
        rst_n = 1'b1;
        cyc();

        do_start();
        lit("start_busy", int'(busy), 1);
        run_scan(0, 1'b0, "ramp");
        lit_res("ramp", 0, 15, 7);

        do_start();
        run_scan(1, 1'b0, "odd");
        lit_res("odd", 3, -15, 15);

        do_start();
        run_scan(2, 1'b1, "sat");
        lit_res("sat", 65535, -16, -16);

        do_start();
        run_scan(3, 1'b0, "tie");
        lit_res("tie", 100, -16, -11);

        // Async reset mid-scan.
        do_start();
        for (int i = 0; i < 500; i++) send(sad_for(6, i), 1'b1);
        #2 rst_n = 1'b0;
        #1;
        lit("arst_busy", int'(busy), 0);
        lit("arst_done", int'(done), 0);
        lit_res("arst", 65535, 0, 0);
        cyc(); cyc(); cyc();
        rst_n = 1'b1;
        d0 = done_cnt;
        for (int i = 0; i < 100; i++) send(7, 1'b1);
        lit("idle_busy", int'(busy), 0);
        lit("idle_done_cnt", done_cnt - d0, 0);
        lit_res("idle", 65535, 0, 0);

        // Abort: start coincides with a sad=0 valid that must be dropped.
        do_start();
        for (int i = 0; i < 300; i++) send(50, 1'b1);
        start = 1'b1; valid = 1'b1; sad = 16'd0;
        cyc();
        start = 1'b0; valid = 1'b0;
        d0 = done_cnt;
        run_scan(4, 1'b0, "abort");
        lit_res("abort", 77, -16, -16);
        lit("abort_done_cnt", done_cnt - d0, 1);

        // Back-to-back random stream, checked against the model.
        do_start();
        run_scan(5, 1'b1, "b2b");
        lit("b2b_min", int'(min_sad), m_min);
        lit("b2b_mvx", int'(mv_x), m_mx);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
